regfile_writeback: RTL

//  Write-back end of the integer register file read by the decode stage: owns the 32 x XLEN

---
 rtl/regfile_writeback_pkg.sv | 14 +
 rtl/regfile_scoreboard.sv | 43 ++++
 rtl/regfile_writeback.sv | 82 ++++++++
 3 files changed

// File: rtl/regfile_writeback_pkg.sv
// rtl/regfile_writeback_pkg.sv - shared register-file widths, x0 constant and decode opcodes
package regfile_writeback_pkg;

  localparam int XLEN = 64;
  localparam int NREG = 32;
  localparam int AW   = 5;

  localparam logic [AW-1:0] REG_ZERO = 5'd0;

  // RV64 major opcodes already used by decode
  localparam logic [6:0] OPC_R_ALU = 7'b0110011;
  localparam logic [6:0] OPC_I_ALU = 7'b0010011;

endpackage

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - per-register busy bits, set at issue and cleared at commit
//
// Ports:
//   CLK, RST          clock, asynchronous active-high reset
//   set_en, set_rd    mark set_rd busy (caller filters x0)
//   clr_en, clr_rd    commit to clr_rd this cycle (caller filters x0)
//   ra1, ra2          operand addresses
//   busy1, busy2      operand still has an uncommitted writer
module regfile_scoreboard
  import regfile_writeback_pkg::*;
(
  input  logic          CLK,
  input  logic          RST,
  input  logic          set_en,
  input  logic [AW-1:0] set_rd,
  input  logic          clr_en,
  input  logic [AW-1:0] clr_rd,
  input  logic [AW-1:0] ra1,
  input  logic [AW-1:0] ra2,
  output logic          busy1,
  output logic          busy2
);

  logic [NREG-1:0] busy;

  // The set is applied after the clear so that a re-issue to a register
  // being committed in the same cycle leaves it busy (newer writer wins).
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      busy <= '0;
    end else begin
      if (clr_en) busy[clr_rd] <= 1'b0;
      if (set_en) busy[set_rd] <= 1'b1;
    end
  end

  // An operand being committed right now is bypassed, so it is not busy.
  always_comb begin
    busy1 = busy[ra1] && !(clr_en && (clr_rd == ra1));
    busy2 = busy[ra2] && !(clr_en && (clr_rd == ra2));
  end

endmodule

// File: rtl/regfile_writeback.sv
// rtl/regfile_writeback.sv - register array with ALU/load write-back arbitration and read bypass
//
// Ports:
//   CLK, RST                      clock, asynchronous active-high reset
//   alu_valid, alu_rd, alu_data   ALU result, always accepted
//   ld_valid, ld_ready            load result handshake (ALU has priority)
//   ld_rd, ld_data                load destination and data
//   issue_valid, issue_rd         destination to mark busy at issue
//   ra1, ra2 / rd1, rd2           combinational read ports with commit bypass
//   busy1, busy2                  operand has an uncommitted writer
//   retired                       count of committed non-x0 writes (wraps)
module regfile_writeback
  import regfile_writeback_pkg::*;
#(
  parameter int CNTW = 32
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            alu_valid,
  input  logic [AW-1:0]   alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            ld_valid,
  output logic            ld_ready,
  input  logic [AW-1:0]   ld_rd,
  input  logic [XLEN-1:0] ld_data,
  input  logic            issue_valid,
  input  logic [AW-1:0]   issue_rd,
  input  logic [AW-1:0]   ra1,
  input  logic [AW-1:0]   ra2,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2,
  output logic            busy1,
  output logic            busy2,
  output logic [CNTW-1:0] retired
);

  logic [XLEN-1:0] regs [NREG];
  logic            commit_wr;
  logic [AW-1:0]   commit_rd;
  logic [XLEN-1:0] commit_data;

  assign ld_ready = !alu_valid;

  // x0 writes still complete the handshake but never reach state. Gating with
  // RST keeps the bypass path from leaking data while the array reads zero.
  always_comb begin
    commit_rd   = alu_valid ? alu_rd : ld_rd;
    commit_data = alu_valid ? alu_data : ld_data;
    commit_wr   = (alu_valid || ld_valid) && (commit_rd != REG_ZERO) && !RST;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
      retired <= '0;
    end else if (commit_wr) begin
      regs[commit_rd] <= commit_data;
      retired         <= retired + CNTW'(1);
    end
  end

  always_comb begin
    rd1 = '0;
    rd2 = '0;
    if (ra1 != REG_ZERO) rd1 = (commit_wr && (ra1 == commit_rd)) ? commit_data : regs[ra1];
    if (ra2 != REG_ZERO) rd2 = (commit_wr && (ra2 == commit_rd)) ? commit_data : regs[ra2];
  end

  regfile_scoreboard u_scoreboard (
    .CLK    (CLK),
    .RST    (RST),
    .set_en (issue_valid && (issue_rd != REG_ZERO)),
    .set_rd (issue_rd),
    .clr_en (commit_wr),
    .clr_rd (commit_rd),
    .ra1    (ra1),
    .ra2    (ra2),
    .busy1  (busy1),
    .busy2  (busy2)
  );

endmodule
